// File: rtl/ps2_scancode_receiver_if.sv
// ps2_scancode_receiver_if: PS/2 pins plus decoded scan-code outputs
interface ps2_scancode_receiver_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;
  logic       ps2_key_extended;
  logic [7:0] ps2_out;
  logic       frame_error;
  modport master (
    output ps2_clk, ps2_dat,
    input  ps2_key_data, ps2_key_pressed, ps2_key_extended, ps2_out, frame_error
  );
  modport slave (
    input  ps2_clk, ps2_dat,
    output ps2_key_data, ps2_key_pressed, ps2_key_extended, ps2_out, frame_error
  );
endinterface

// File: rtl/ps2_scancode_receiver.sv
// ps2_scancode_receiver: PS/2 device-to-host deserialiser with F0/E0 prefix stripping
module ps2_scancode_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic clock,
  input logic reset,
  ps2_scancode_receiver_if.slave bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  logic [1:0]    clk_s, dat_s;
  logic          clk_f, dat_f, fall;
  logic [FW-1:0] clk_n, dat_n;
  state_t        state;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par, brk, ext;
  logic [TW-1:0] tcnt;
  // a filtered level only flips after FILTER_LEN consecutive opposite samples
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      clk_f <= 1'b1;
      dat_f <= 1'b1;
      clk_n <= '0;
      dat_n <= '0;
      fall  <= 1'b0;
    end else begin
      clk_s <= {clk_s[0], bus.ps2_clk};
      dat_s <= {dat_s[0], bus.ps2_dat};
      fall  <= 1'b0;
      if (clk_s[1] == clk_f) clk_n <= '0;
      else if (clk_n == FW'(FILTER_LEN - 1)) begin
        clk_n <= '0;
        clk_f <= clk_s[1];
        fall  <= clk_f;
      end else clk_n <= clk_n + 1'b1;
      if (dat_s[1] == dat_f) dat_n <= '0;
      else if (dat_n == FW'(FILTER_LEN - 1)) begin
        dat_n <= '0;
        dat_f <= dat_s[1];
      end else dat_n <= dat_n + 1'b1;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      bitcnt               <= '0;
      shreg                <= '0;
      par                  <= 1'b0;
      brk                  <= 1'b0;
      ext                  <= 1'b0;
      tcnt                 <= '0;
      bus.ps2_key_data     <= '0;
      bus.ps2_key_pressed  <= 1'b0;
      bus.ps2_key_extended <= 1'b0;
      bus.ps2_out          <= '0;
      bus.frame_error      <= 1'b0;
    end else begin
      bus.ps2_key_pressed <= 1'b0;
      bus.frame_error     <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        case (state)
          IDLE: if (!dat_f) begin
            state  <= DATA;
            bitcnt <= '0;
          end
          DATA: begin
            shreg  <= {dat_f, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= dat_f;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (dat_f && (^{shreg, par})) begin
              bus.ps2_out <= shreg;
              if (shreg == 8'hF0) brk <= 1'b1;
              else if (shreg == 8'hE0) ext <= 1'b1;
              else if (brk) begin
                brk <= 1'b0;
                ext <= 1'b0;
              end else begin
                bus.ps2_key_data     <= shreg;
                bus.ps2_key_extended <= ext;
                bus.ps2_key_pressed  <= 1'b1;
                ext                  <= 1'b0;
              end
            end else begin
              bus.frame_error <= 1'b1;
              brk             <= 1'b0;
              ext             <= 1'b0;
            end
          end
        endcase
      end else if (state == IDLE) tcnt <= '0;
      else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        bus.frame_error <= 1'b1;
        state           <= IDLE;
        tcnt            <= '0;
      end else tcnt <= tcnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// tb_ps2_scancode_receiver: random and directed PS/2 frames against a byte-level key model
module tb_ps2_scancode_receiver;
  localparam int HALF = 20;
  localparam int TMO  = 3000;
  logic clock = 1'b0;
  logic reset = 1'b1;
  ps2_scancode_receiver_if bus();
  ps2_scancode_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  int total = 0;
  int bad = 0;
  int n_press = 0;
  int n_err = 0;
  int n_both = 0;
  logic seen_ext = 1'b0;
  logic brk = 1'b0;
  logic ext = 1'b0;
  logic [7:0] m_out = '0;
  logic [7:0] m_data = '0;
  always @(negedge clock) begin
    if (bus.ps2_key_pressed) begin
      n_press++;
      seen_ext = bus.ps2_key_extended;
    end
    if (bus.frame_error) n_err++;
    if (bus.ps2_key_pressed && bus.frame_error) n_both++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic bit_out(input logic b);
    bus.ps2_dat = b;
    cyc(HALF);
    bus.ps2_clk = 1'b0;
    cyc(HALF);
    bus.ps2_clk = 1'b1;
  endtask
  task automatic send(input logic [7:0] b, input bit bp, input bit bs, input bit gl);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) begin
      bit_out(b[i]);
      if (gl && i == 3) begin
        cyc(5);
        bus.ps2_clk = 1'b0;
        cyc(3);
        bus.ps2_clk = 1'b1;
      end
    end
    bit_out(~^b ^ bp);
    bit_out(!bs);
    bus.ps2_dat = 1'b1;
  endtask
  task automatic xfer(input logic [7:0] b, input bit bp = 0, input bit bs = 0, input bit gl = 0);
    int p0, e0;
    logic ep, ee, me;
    p0 = n_press;
    e0 = n_err;
    send(b, bp, bs, gl);
    cyc(30);
    ep = 1'b0;
    me = 1'b0;
    ee = bp | bs;
    if (ee) begin
      brk = 1'b0;
      ext = 1'b0;
    end else begin
      m_out = b;
      if (b == 8'hF0) brk = 1'b1;
      else if (b == 8'hE0) ext = 1'b1;
      else if (brk) begin
        brk = 1'b0;
        ext = 1'b0;
      end else begin
        ep = 1'b1;
        m_data = b;
        me = ext;
        ext = 1'b0;
      end
    end
    chk($sformatf("press_%h", b), n_press - p0, {31'd0, ep});
    chk($sformatf("err_%h", b), n_err - e0, {31'd0, ee});
    chk($sformatf("out_%h", b), bus.ps2_out, m_out);
    chk($sformatf("data_%h", b), bus.ps2_key_data, m_data);
    if (ep) begin
      chk($sformatf("ext_pulse_%h", b), seen_ext, me);
      chk($sformatf("ext_hold_%h", b), bus.ps2_key_extended, me);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_out"}, bus.ps2_out, 0);
    chk({tag, "_data"}, bus.ps2_key_data, 0);
    chk({tag, "_press"}, bus.ps2_key_pressed, 0);
    chk({tag, "_ext"}, bus.ps2_key_extended, 0);
    chk({tag, "_err"}, bus.frame_error, 0);
  endtask
  initial begin
    int p0, e0;
    logic [7:0] b;
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    cyc(3);
    chk_zero("rst");
    reset = 1'b0;
    cyc(5);
    xfer(8'h1C);
    xfer(8'hF0);
    xfer(8'h1C);
    xfer(8'h1C);
    xfer(8'hE0);
    xfer(8'h6B);
    xfer(8'hE0);
    xfer(8'hF0);
    xfer(8'h6B);
    xfer(8'h74);
    xfer(8'h16, 1);
    xfer(8'h16);
    xfer(8'h16, 0, 1);
    p0 = n_press;
    e0 = n_err;
    bit_out(1'b0);
    for (int i = 0; i < 5; i++) bit_out(i[0]);
    bus.ps2_dat = 1'b1;
    cyc(TMO + 100);
    chk("tmo_err", n_err - e0, 1);
    chk("tmo_press", n_press - p0, 0);
    xfer(8'h1E);
    xfer(8'h2A, 0, 0, 1);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    reset = 1'b1;
    cyc(2);
    chk_zero("midrst");
    brk = 1'b0;
    ext = 1'b0;
    m_out = '0;
    m_data = '0;
    bus.ps2_dat = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(5);
    xfer(8'h26);
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 9))
        0: b = 8'hF0;
        1: b = 8'hE0;
        default: b = 8'($urandom);
      endcase
      xfer(b, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    end
    chk("both_high", n_both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
